// File: rtl/fetch_frontend_if.sv
// Handshake bundle between the fetch frontend, instruction memory and decode.
// The master side is the frontend itself; the slave side is its environment.
interface fetch_frontend_if #(
  parameter int XLEN = 32
);
  logic            fetch_en;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            resp_valid;
  logic [XLEN-1:0] resp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;

  modport master (
    input  fetch_en, redirect_valid, redirect_pc, req_ready,
           resp_valid, resp_data, inst_ready,
    output req_valid, req_addr, inst_valid, inst_data, inst_pc
  );

  modport slave (
    output fetch_en, redirect_valid, redirect_pc, req_ready,
           resp_valid, resp_data, inst_ready,
    input  req_valid, req_addr, inst_valid, inst_data, inst_pc
  );
endinterface

// File: rtl/fetch_frontend.sv
// Instruction fetch frontend: issues in-order memory requests under a credit
// limit, queues responses with their PCs, and flushes on redirect.
module fetch_frontend #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  fetch_frontend_if.master bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] resp_pc_reg, resp_pc_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [OW-1:0]   out_reg, out_next;
  logic [OW-1:0]   drop_reg, drop_next;

  logic [XLEN-1:0] data_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];

  logic credit_ok, req_fire, resp_fire, drop, push, pop;

  // Queued entries plus in-flight requests never exceed DEPTH, so a push can never hit a full queue.
  assign credit_ok = (int'(out_reg) < MAX_OUT) &&
                     ((int'(count_reg) + int'(out_reg)) < DEPTH);

  assign bus.req_valid  = (state_reg == FETCH) && !bus.redirect_valid && credit_ok;
  assign bus.req_addr   = pc_reg;
  assign bus.inst_valid = (count_reg != '0) && !bus.redirect_valid;
  assign bus.inst_data  = data_mem[rd_ptr_reg];
  assign bus.inst_pc    = pc_mem[rd_ptr_reg];

  assign req_fire  = bus.req_valid && bus.req_ready;
  assign resp_fire = bus.resp_valid && (out_reg != '0);
  assign drop      = resp_fire && (drop_reg != '0);
  assign push      = resp_fire && (drop_reg == '0) && !bus.redirect_valid;
  assign pop       = bus.inst_valid && bus.inst_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.fetch_en)  state_next = FETCH;
      FETCH:   if (!bus.fetch_en) state_next = HALT;
      HALT:    if (bus.fetch_en)  state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pc_next      = pc_reg;
    resp_pc_next = resp_pc_reg;
    count_next   = count_reg;
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    out_next     = out_reg;
    drop_next    = drop_reg;

    if (req_fire) begin
      pc_next  = pc_reg + XLEN'(4);
      out_next = out_reg + 1'b1;
    end
    if (resp_fire) out_next = out_next - 1'b1;
    if (drop)      drop_next = drop_reg - 1'b1;
    if (push) begin
      wr_ptr_next  = wr_ptr_reg + 1'b1;
      resp_pc_next = resp_pc_reg + XLEN'(4);
    end
    if (pop) rd_ptr_next = rd_ptr_reg + 1'b1;

    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase

    // No request can fire during a redirect, so out_next already equals outstanding minus this cycle's response.
    if (bus.redirect_valid) begin
      pc_next      = bus.redirect_pc;
      resp_pc_next = bus.redirect_pc;
      count_next   = '0;
      wr_ptr_next  = '0;
      rd_ptr_next  = '0;
      drop_next    = out_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_reg   <= IDLE;
      pc_reg      <= RESET_PC;
      resp_pc_reg <= RESET_PC;
      count_reg   <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      out_reg     <= '0;
      drop_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      resp_pc_reg <= resp_pc_next;
      count_reg   <= count_next;
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      out_reg     <= out_next;
      drop_reg    <= drop_next;
    end
  end

  // Storage is read asynchronously so a pushed entry is visible at the head on the very next cycle.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_reg == PW'(gi))) begin
        data_mem[gi] <= bus.resp_data;
        pc_mem[gi]   <= resp_pc_reg;
      end
    end
  end
endmodule

// File: tb/tb_fetch_frontend.sv
// Scenario bench for fetch_frontend: an in-order memory model feeds responses
// and a scoreboard of {pc, data} checks every instruction handed to decode.
module tb_fetch_frontend;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk;
  logic rst_n;
  fetch_frontend_if #(.XLEN(32)) bus ();

  fetch_frontend #(.XLEN(32), .DEPTH(4), .MAX_OUT(2), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors    = 0;
  int          miscompares = 0;
  int          n_acc, n_pop;
  logic [31:0] exp_pc, first_pop_pc;
  logic        mem_hold;
  logic [31:0] mem_q [$];
  logic [63:0] exp_q [$];
  logic [31:0] acc_log [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'hA5A5_5A5A) + 32'h0101_0001;
  endfunction

  // One clock: drive the memory response, sample handshakes, advance, update models.
  task automatic tick();
    logic rf, pf, rd;
    logic [31:0] ra, ip, id, rpc, ma;
    logic [63:0] e;
    bus.resp_valid = 1'b0;
    bus.resp_data  = '0;
    if (!mem_hold && mem_q.size() > 0) begin
      ma = mem_q.pop_front();
      bus.resp_valid = 1'b1;
      bus.resp_data  = mem_word(ma);
    end
    #1;
    rf  = bus.req_valid && bus.req_ready && !rst_n;
    ra  = bus.req_addr;
    pf  = bus.inst_valid && bus.inst_ready && !rst_n;
    ip  = bus.inst_pc;
    id  = bus.inst_data;
    rd  = bus.redirect_valid && !rst_n;
    rpc = bus.redirect_pc;
    @(posedge clk);
    #1;
    if (rst_n) begin
      exp_q.delete();
      exp_pc = RESET_PC;
    end else begin
      if (pf) begin
        n_pop++;
        if (n_pop == 1) first_pop_pc = ip;
        $display("pop  pc=%h data=%h", ip, id);
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL pop_unexpected: got pc=%h data=%h, required no instruction", ip, id);
        end else begin
          e = exp_q.pop_front();
          if ({ip, id} !== e) begin
            miscompares++;
            $display("FAIL pop_entry: got pc=%h data=%h, required pc=%h data=%h",
                     ip, id, e[63:32], e[31:0]);
          end
        end
      end
      if (rd) begin
        exp_q.delete();
        exp_pc = rpc;
      end
      if (rf) begin
        vectors++;
        if (ra !== exp_pc) begin
          miscompares++;
          $display("FAIL req_addr: got %h, required %h", ra, exp_pc);
        end
        exp_pc += 32'd4;
        n_acc++;
        acc_log.push_back(ra);
        mem_q.push_back(ra);
        exp_q.push_back({ra, mem_word(ra)});
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    bus.fetch_en = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.req_ready = 1'b0;
    bus.inst_ready = 1'b0;
    mem_hold = 1'b0;
    mem_q.delete();
    repeat (2) tick();
    rst_n = 1'b0;
    n_acc = 0;
    n_pop = 0;
    first_pop_pc = 32'hDEAD_DEAD;
    acc_log.delete();
  endtask

  task automatic drain();
    bus.fetch_en = 1'b0;
    bus.inst_ready = 1'b1;
    mem_hold = 1'b0;
    repeat (10) tick();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_left: got %0d undelivered, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.fetch_en = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.req_ready = 1'b1;
    bus.inst_ready = 1'b1;
    mem_hold = 1'b0;
    repeat (2) tick();
    vectors++;
    if (bus.req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_req_valid: got %b, required 0", bus.req_valid); end
    vectors++;
    if (bus.inst_valid !== 1'b0) begin miscompares++; $display("FAIL reset_inst_valid: got %b, required 0", bus.inst_valid); end
    vectors++;
    if (bus.req_addr !== RESET_PC) begin miscompares++; $display("FAIL reset_req_addr: got %h, required %h", bus.req_addr, RESET_PC); end
    rst_n = 1'b0;
    bus.fetch_en = 1'b0;
    repeat (2) tick();
    vectors++;
    if (bus.req_valid !== 1'b0) begin miscompares++; $display("FAIL idle_req_valid: got %b, required 0", bus.req_valid); end
  endtask

  task automatic test_sequential();
    do_reset();
    bus.fetch_en = 1'b1;
    bus.req_ready = 1'b1;
    bus.inst_ready = 1'b1;
    repeat (24) tick();
    vectors++;
    if (acc_log[0] !== 32'h0 || acc_log[1] !== 32'h4 || acc_log[2] !== 32'h8) begin
      miscompares++;
      $display("FAIL seq_addrs: got %h %h %h, required 0 4 8", acc_log[0], acc_log[1], acc_log[2]);
    end
    vectors++;
    if (n_pop < 18) begin miscompares++; $display("FAIL seq_throughput: got %0d pops, required >= 18", n_pop); end
    vectors++;
    if (first_pop_pc !== 32'h0) begin miscompares++; $display("FAIL seq_first_pc: got %h, required 0", first_pop_pc); end
    drain();
  endtask

  task automatic test_full();
    do_reset();
    bus.fetch_en = 1'b1;
    bus.req_ready = 1'b1;
    repeat (10) tick();
    vectors++;
    if (n_acc != 4) begin miscompares++; $display("FAIL full_accepts: got %0d, required 4", n_acc); end
    vectors++;
    if (bus.req_valid !== 1'b0) begin miscompares++; $display("FAIL full_req_valid: got %b, required 0", bus.req_valid); end
    vectors++;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== exp_q[0][63:32] || bus.inst_data !== exp_q[0][31:0]) begin
      miscompares++;
      $display("FAIL full_head: got v=%b pc=%h data=%h, required v=1 pc=%h data=%h",
               bus.inst_valid, bus.inst_pc, bus.inst_data, exp_q[0][63:32], exp_q[0][31:0]);
    end
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    repeat (6) tick();
    vectors++;
    if (n_acc != 5) begin miscompares++; $display("FAIL full_refill: got %0d accepts, required 5", n_acc); end
    vectors++;
    if (acc_log[4] !== 32'h10) begin miscompares++; $display("FAIL full_refill_addr: got %h, required 10", acc_log[4]); end
    drain();
    vectors++;
    if (n_pop != 5) begin miscompares++; $display("FAIL full_pops: got %0d, required 5", n_pop); end
  endtask

  task automatic test_redirect();
    do_reset();
    mem_hold = 1'b1;
    bus.fetch_en = 1'b1;
    bus.req_ready = 1'b1;
    bus.inst_ready = 1'b1;
    repeat (4) tick();
    vectors++;
    if (n_acc != 2) begin miscompares++; $display("FAIL redir_outstanding: got %0d, required 2", n_acc); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h100;
    tick();
    bus.redirect_valid = 1'b0;
    vectors++;
    if (bus.req_addr !== 32'h100) begin miscompares++; $display("FAIL redir_req_addr: got %h, required 100", bus.req_addr); end
    mem_hold = 1'b0;
    repeat (12) tick();
    vectors++;
    if (first_pop_pc !== 32'h100) begin miscompares++; $display("FAIL redir_first_pc: got %h, required 100", first_pop_pc); end
    vectors++;
    if (acc_log[2] !== 32'h100) begin miscompares++; $display("FAIL redir_next_req: got %h, required 100", acc_log[2]); end
    drain();
  endtask

  task automatic test_redirect_resp();
    do_reset();
    mem_hold = 1'b1;
    bus.fetch_en = 1'b1;
    bus.req_ready = 1'b1;
    bus.inst_ready = 1'b1;
    repeat (4) tick();
    mem_hold = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h200;
    tick();
    bus.redirect_valid = 1'b0;
    repeat (12) tick();
    vectors++;
    if (first_pop_pc !== 32'h200) begin miscompares++; $display("FAIL redir_resp_first_pc: got %h, required 200", first_pop_pc); end
    vectors++;
    if (n_pop < 3) begin miscompares++; $display("FAIL redir_resp_pops: got %0d, required >= 3", n_pop); end
    drain();
  endtask

  task automatic test_halt();
    do_reset();
    mem_hold = 1'b1;
    bus.fetch_en = 1'b1;
    bus.req_ready = 1'b1;
    bus.inst_ready = 1'b1;
    repeat (4) tick();
    bus.fetch_en = 1'b0;
    tick();
    mem_hold = 1'b0;
    repeat (6) tick();
    vectors++;
    if (n_acc != 2) begin miscompares++; $display("FAIL halt_no_req: got %0d accepts, required 2", n_acc); end
    vectors++;
    if (n_pop != 2) begin miscompares++; $display("FAIL halt_delivered: got %0d pops, required 2", n_pop); end
    vectors++;
    if (bus.req_valid !== 1'b0) begin miscompares++; $display("FAIL halt_req_valid: got %b, required 0", bus.req_valid); end
    bus.fetch_en = 1'b1;
    repeat (4) tick();
    vectors++;
    if (acc_log[2] !== 32'h8) begin miscompares++; $display("FAIL halt_resume_addr: got %h, required 8", acc_log[2]); end
    drain();
  endtask

  task automatic test_wrap();
    do_reset();
    bus.fetch_en = 1'b1;
    bus.inst_ready = 1'b1;
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFF8;
    tick();
    bus.redirect_valid = 1'b0;
    bus.req_ready = 1'b1;
    repeat (8) tick();
    vectors++;
    if (acc_log[0] !== 32'hFFFF_FFF8 || acc_log[1] !== 32'hFFFF_FFFC || acc_log[2] !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_addrs: got %h %h %h, required fffffff8 fffffffc 0", acc_log[0], acc_log[1], acc_log[2]);
    end
    vectors++;
    if (first_pop_pc !== 32'hFFFF_FFF8) begin miscompares++; $display("FAIL wrap_first_pc: got %h, required fffffff8", first_pop_pc); end
    drain();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    mem_hold = 1'b1;
    bus.fetch_en = 1'b1;
    bus.req_ready = 1'b1;
    bus.inst_ready = 1'b1;
    repeat (4) tick();
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    bus.fetch_en = 1'b0;
    mem_hold = 1'b0;
    repeat (4) tick();
    vectors++;
    if (bus.inst_valid !== 1'b0) begin miscompares++; $display("FAIL stale_inst_valid: got %b, required 0", bus.inst_valid); end
    vectors++;
    if (n_pop != 0) begin miscompares++; $display("FAIL stale_pops: got %0d, required 0", n_pop); end
    vectors++;
    if (bus.req_addr !== RESET_PC) begin miscompares++; $display("FAIL stale_req_addr: got %h, required %h", bus.req_addr, RESET_PC); end
    bus.fetch_en = 1'b1;
    repeat (8) tick();
    vectors++;
    if (acc_log[2] !== RESET_PC) begin miscompares++; $display("FAIL restart_addr: got %h, required %h", acc_log[2], RESET_PC); end
    vectors++;
    if (first_pop_pc !== RESET_PC) begin miscompares++; $display("FAIL restart_first_pc: got %h, required %h", first_pop_pc, RESET_PC); end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    bus.resp_valid = 1'b0;
    bus.resp_data = '0;
    n_acc = 0;
    n_pop = 0;
    exp_pc = RESET_PC;
    first_pop_pc = '0;
    test_reset();
    test_sequential();
    test_full();
    test_redirect();
    test_redirect_resp();
    test_halt();
    test_wrap();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
